mem_port_arbiter: RTL

//  Shares one single-port, variable-latency memory between instruction fetch (IF, read-only)
//  and the MEM stage (loads/stores driven by decoded mem_read/mem_write).

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port, variable-latency memory between the
// instruction-fetch port and the data (load/store) port. One access is in
// flight at a time. Addresses and write data are latched when the access is
// granted. Acks and read data are registered. A watchdog aborts an access
// whose memory never answers.
//
// Handshake semantics:
//   requester side: *_req is raised with its fields stable and held until
//   the one-cycle *_ack pulse. The acked side is masked from arbitration in
//   its ack cycle, so a still-high req is treated as a new access starting
//   the following cycle.
//   memory side: mem_req behaves as valid and mem_ready as ready. The access
//   completes on the first rising edge that samples mem_req=1 and
//   mem_ready=1. mem_ready is ignored whenever mem_req is 0.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err,
  output logic              stall,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_e;

  // The watchdog counts 0..TIMEOUT-1. The abort fires in the cycle that holds the last value.
  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic              WD_EN    = (TIMEOUT > 0);
  localparam logic              D_FIRST  = (DATA_PRIORITY != 0);

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                bus_err_q, bus_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic elig_if, elig_d, grant_if, grant_d, fin, timed_out;

  // State and registered outputs. An async reset abandons any access without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Arbitration, memory handshake, watchdog and ack generation.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    cnt_d       = cnt_q;
    fin         = 1'b0;
    timed_out   = 1'b0;

    // The side acked this cycle is masked. Its ack register doubles as the mask.
    elig_if  = if_req & ~if_ack_q;
    elig_d   = d_req & ~d_ack_q;
    grant_d  = elig_d & (D_FIRST | ~elig_if);
    grant_if = elig_if & ~grant_d;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          cnt_d       = '0;
        end else if (grant_if) begin
          state_d     = IF_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          cnt_d       = '0;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ready) begin
          fin = 1'b1;
        end else if (WD_EN && (cnt_q == CNT_LAST)) begin
          fin       = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (fin) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = timed_out;
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = timed_out ? '0 : mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = timed_out ? '0 : mem_rdata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_ack      = if_ack_q;
  assign if_rdata    = if_rdata_q;
  assign d_ack       = d_ack_q;
  assign d_rdata     = d_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign bus_err     = bus_err_q;
  assign stall       = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);
  assign dbg_state_o = state_q;

endmodule
